// File: rtl/cavlc_blk_scheduler.sv
// Walks the 16 luma 4x4 blocks of one macroblock through the CAVLC core and
// derives each block's nC context from left/top neighbour total_coeff values.
module cavlc_blk_scheduler #(
   parameter int unsigned MB_COLS = 20,
   parameter int unsigned MBX_W   = 5,
   parameter int unsigned MBY_W   = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mb_start_i,
   input  logic [MBX_W-1:0] mb_x_i,
   input  logic [MBY_W-1:0] mb_y_i,
   output logic             mb_ready_o,
   output logic             mb_done_o,
   output logic             blk_rd_en_o,
   output logic [3:0]       blk_rd_idx_o,
   output logic             cavlc_valid_o,
   output logic [4:0]       nc_o,
   input  logic             cavlc_done_i,
   input  logic [4:0]       total_coeff_i
);

   localparam int unsigned TopN = MB_COLS * 4;
   localparam int unsigned TopW = $clog2(TopN);

   typedef enum logic [2:0] {StIdle, StRd, StIssue, StWait, StNext, StDone} state_e;

   state_e           state_q, state_d;
   logic [3:0]       idx_q, idx_d;
   logic [MBX_W-1:0] mb_x_q, mb_x_d;
   logic [MBY_W-1:0] mb_y_q, mb_y_d;
   logic [4:0]       nc_q, nc_d;
   logic [4:0]       cur_q  [16];
   logic [4:0]       left_q [4];
   logic [4:0]       top_q  [TopN];

   logic             cur_we, top_we, left_we;
   logic [1:0]       x4, y4;
   logic [31:0]      top_pos;
   logic [TopW-1:0]  top_idx;
   logic             top_ok;
   logic             na_ok, nb_ok;
   logic [4:0]       na, nb, nc_calc, tc_sat;
   logic [5:0]       sum6;

   // Raster position inside the MB -> H.264 luma 4x4 scan index.
   function automatic logic [3:0] blk_idx(input logic [1:0] x, input logic [1:0] y);
      return {y[1], x[1], y[0], x[0]};
   endfunction

   assign x4      = {idx_q[2], idx_q[0]};
   assign y4      = {idx_q[3], idx_q[1]};
   assign top_pos = 32'({mb_x_q, x4});
   assign top_idx = top_pos[TopW-1:0];
   assign top_ok  = (top_pos < TopN);
   assign tc_sat  = (total_coeff_i > 5'd16) ? 5'd16 : total_coeff_i;

   always_comb begin
      na_ok = 1'b0;
      nb_ok = 1'b0;
      na    = 5'd0;
      nb    = 5'd0;
      if (x4 != 2'd0) begin
         na_ok = 1'b1;
         na    = cur_q[blk_idx(x4 - 2'd1, y4)];
      end else if (mb_x_q != '0) begin
         na_ok = 1'b1;
         na    = left_q[y4];
      end
      if (y4 != 2'd0) begin
         nb_ok = 1'b1;
         nb    = cur_q[blk_idx(x4, y4 - 2'd1)];
      end else if (mb_y_q != '0) begin
         nb_ok = 1'b1;
         nb    = top_ok ? top_q[top_idx] : 5'd0;
      end
      sum6 = {1'b0, na} + {1'b0, nb} + 6'd1;
      if (na_ok && nb_ok) nc_calc = sum6[5:1];
      else if (na_ok)     nc_calc = na;
      else if (nb_ok)     nc_calc = nb;
      else                nc_calc = 5'd0;
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      mb_x_d  = mb_x_q;
      mb_y_d  = mb_y_q;
      nc_d    = nc_q;
      cur_we  = 1'b0;
      top_we  = 1'b0;
      left_we = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (mb_start_i) begin
               mb_x_d  = mb_x_i;
               mb_y_d  = mb_y_i;
               idx_d   = 4'd0;
               state_d = StRd;
            end
         end
         StRd: begin
            nc_d    = nc_calc;
            state_d = StIssue;
         end
         StIssue: state_d = StWait;
         StWait: begin
            if (cavlc_done_i) begin
               cur_we  = 1'b1;
               // Bottom row feeds the MB below; its own top reads happened in row 0.
               top_we  = (y4 == 2'd3) && top_ok;
               state_d = StNext;
            end
         end
         StNext: begin
            if (idx_q == 4'd15) begin
               state_d = StDone;
            end else begin
               idx_d   = idx_q + 4'd1;
               state_d = StRd;
            end
         end
         StDone: begin
            left_we = 1'b1;
            idx_d   = 4'd0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         idx_q   <= 4'd0;
         mb_x_q  <= '0;
         mb_y_q  <= '0;
         nc_q    <= 5'd0;
         for (int i = 0; i < 16; i++) cur_q[i] <= 5'd0;
         for (int i = 0; i < 4; i++) left_q[i] <= 5'd0;
         for (int i = 0; i < int'(TopN); i++) top_q[i] <= 5'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         mb_x_q  <= mb_x_d;
         mb_y_q  <= mb_y_d;
         nc_q    <= nc_d;
         if (cur_we) cur_q[idx_q] <= tc_sat;
         if (top_we) top_q[top_idx] <= tc_sat;
         if (left_we) begin
            for (int i = 0; i < 4; i++) left_q[i] <= cur_q[blk_idx(2'd3, 2'(i))];
         end
      end
   end

   assign mb_ready_o    = (state_q == StIdle);
   assign mb_done_o     = (state_q == StDone);
   assign blk_rd_en_o   = (state_q == StRd);
   assign cavlc_valid_o = (state_q == StIssue);
   assign blk_rd_idx_o  = idx_q;
   assign nc_o          = nc_q;

endmodule

// File: tb/tb_cavlc_blk_scheduler.sv
// Directed bench for cavlc_blk_scheduler: a scripted CAVLC core answers each
// block and the captured nC values are compared with hand-derived numbers.
module tb_cavlc_blk_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       mb_start_i = 1'b0;
   logic [4:0] mb_x_i = '0;
   logic [6:0] mb_y_i = '0;
   logic       cavlc_done_i = 1'b0;
   logic [4:0] total_coeff_i = '0;
   logic       mb_ready_o, mb_done_o, blk_rd_en_o, cavlc_valid_o;
   logic [3:0] blk_rd_idx_o;
   logic [4:0] nc_o;

   int errors = 0;
   int checks = 0;
   int rd_cnt = 0;
   int vl_cnt = 0;
   int stall_cyc = 0;
   bit spurious = 1'b0;
   bit busy_start = 1'b0;
   logic [4:0] tc_tab  [16];
   logic [4:0] nc_seen [16];

   cavlc_blk_scheduler #(.MB_COLS(20), .MBX_W(5), .MBY_W(7)) dut (
      .clk          (clk),
      .rst          (rst),
      .mb_start_i   (mb_start_i),
      .mb_x_i       (mb_x_i),
      .mb_y_i       (mb_y_i),
      .mb_ready_o   (mb_ready_o),
      .mb_done_o    (mb_done_o),
      .blk_rd_en_o  (blk_rd_en_o),
      .blk_rd_idx_o (blk_rd_idx_o),
      .cavlc_valid_o(cavlc_valid_o),
      .nc_o         (nc_o),
      .cavlc_done_i (cavlc_done_i),
      .total_coeff_i(total_coeff_i)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (blk_rd_en_o) rd_cnt <= rd_cnt + 1;
      if (cavlc_valid_o) vl_cnt <= vl_cnt + 1;
   end

   // Runs one MB; stop_blk < 16 abandons it while that block sits in WAIT.
   task automatic run_mb(input int x, input int y, input int stop_blk);
      int n;
      int rd0, vl0;
      logic [4:0] nc_hold;
      rd0 = rd_cnt;
      vl0 = vl_cnt;
      @(negedge clk);
      mb_x_i = 5'(x);
      mb_y_i = 7'(y);
      mb_start_i = 1'b1;
      @(negedge clk);
      mb_start_i = 1'b0;
      for (int b = 0; b < 16; b++) begin
         n = 0;
         while (!blk_rd_en_o && n < 50) begin
            @(negedge clk);
            n++;
         end
         checks++;
         if (blk_rd_en_o !== 1'b1) begin
            errors++;
            $display("FAIL rd_timeout blk=%0d got rd_en=%b want 1", b, blk_rd_en_o);
            return;
         end
         checks++;
         if (blk_rd_idx_o !== b[3:0]) begin
            errors++;
            $display("FAIL rd_idx got %0d want %0d", blk_rd_idx_o, b);
         end
         if (spurious && b == 0) begin
            cavlc_done_i = 1'b1;
            total_coeff_i = 5'd0;
         end
         @(negedge clk);
         cavlc_done_i = 1'b0;
         checks++;
         if (cavlc_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL valid blk=%0d got %b want 1", b, cavlc_valid_o);
         end
         nc_seen[b] = nc_o;
         nc_hold = nc_o;
         if (b == stop_blk) begin
            @(negedge clk);
            return;
         end
         if (busy_start && b == 3) begin
            checks++;
            if (mb_ready_o !== 1'b0) begin
               errors++;
               $display("FAIL busy_ready got %b want 0", mb_ready_o);
            end
            mb_start_i = 1'b1;
            mb_x_i = 5'd0;
            mb_y_i = 7'd0;
         end
         for (int s = 0; s < stall_cyc; s++) begin
            @(negedge clk);
            mb_start_i = 1'b0;
            checks++;
            if (nc_o !== nc_hold || blk_rd_en_o !== 1'b0 || cavlc_valid_o !== 1'b0) begin
               errors++;
               $display("FAIL stall blk=%0d got nc=%0d rd=%b vl=%b want nc=%0d rd=0 vl=0",
                        b, nc_o, blk_rd_en_o, cavlc_valid_o, nc_hold);
            end
         end
         @(negedge clk);
         mb_start_i = 1'b0;
         cavlc_done_i = 1'b1;
         total_coeff_i = tc_tab[b];
         @(negedge clk);
         cavlc_done_i = 1'b0;
      end
      n = 0;
      while (!mb_done_o && n < 10) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (mb_done_o !== 1'b1) begin
         errors++;
         $display("FAIL mb_done got %b want 1", mb_done_o);
      end
      @(negedge clk);
      checks++;
      if (mb_done_o !== 1'b0 || mb_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL done_pulse got done=%b ready=%b want done=0 ready=1",
                  mb_done_o, mb_ready_o);
      end
      checks++;
      if (rd_cnt - rd0 != 16 || vl_cnt - vl0 != 16) begin
         errors++;
         $display("FAIL pulse_count got rd=%0d vl=%0d want 16 16", rd_cnt - rd0, vl_cnt - vl0);
      end
   endtask

   task automatic chk_nc(input int b, input logic [4:0] want);
      checks++;
      if (nc_seen[b] !== want) begin
         errors++;
         $display("FAIL nc blk=%0d got %0d want %0d", b, nc_seen[b], want);
      end
   endtask

   task automatic chk_idle(input string tag);
      checks++;
      if (mb_ready_o !== 1'b1 || mb_done_o !== 1'b0 || blk_rd_en_o !== 1'b0 ||
          cavlc_valid_o !== 1'b0 || blk_rd_idx_o !== 4'd0 || nc_o !== 5'd0) begin
         errors++;
         $display("FAIL %s got rdy=%b done=%b rd=%b vl=%b idx=%0d nc=%0d want 1 0 0 0 0 0",
                  tag, mb_ready_o, mb_done_o, blk_rd_en_o, cavlc_valid_o, blk_rd_idx_o, nc_o);
      end
   endtask

   task automatic test_reset();
      #12;
      chk_idle("reset_init");
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 16; i++) tc_tab[i] = 5'd1;
      run_mb(0, 0, 7);
      checks++;
      if (blk_rd_idx_o !== 4'd7 || nc_o !== 5'd1 || mb_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL pre_reset got idx=%0d nc=%0d rdy=%b want 7 1 0",
                  blk_rd_idx_o, nc_o, mb_ready_o);
      end
      #2 rst = 1'b0;
      #1 chk_idle("reset_mid_mb");
      @(negedge clk);
      @(negedge clk);
      chk_idle("reset_held");
      rst = 1'b1;
   endtask

   task automatic test_mb00();
      for (int i = 0; i < 16; i++) tc_tab[i] = 5'(i);
      run_mb(0, 0, 16);
      chk_nc(0, 5'd0);
      chk_nc(1, 5'd0);
      chk_nc(2, 5'd0);
      chk_nc(3, 5'd2);
      chk_nc(15, 5'd14);
   endtask

   task automatic test_mb10();
      for (int i = 0; i < 16; i++) tc_tab[i] = 5'd16;
      run_mb(1, 0, 16);
      chk_nc(0, 5'd5);
      chk_nc(2, 5'd12);
      chk_nc(15, 5'd16);
   endtask

   task automatic test_mb01();
      for (int i = 0; i < 16; i++) tc_tab[i] = 5'd10;
      run_mb(0, 1, 16);
      chk_nc(0, 5'd10);
      chk_nc(1, 5'd11);
      chk_nc(5, 5'd13);
   endtask

   task automatic test_stall();
      for (int i = 0; i < 16; i++) tc_tab[i] = 5'd4;
      stall_cyc = 20;
      spurious = 1'b1;
      run_mb(1, 1, 16);
      stall_cyc = 0;
      spurious = 1'b0;
      chk_nc(0, 5'd13);
      chk_nc(1, 5'd10);
   endtask

   task automatic test_busy_sat();
      for (int i = 0; i < 16; i++) tc_tab[i] = 5'd31;
      busy_start = 1'b1;
      run_mb(2, 1, 16);
      busy_start = 1'b0;
      chk_nc(0, 5'd2);
      chk_nc(1, 5'd8);
      chk_nc(3, 5'd16);
      chk_nc(5, 5'd8);
   endtask

   initial begin
      test_reset();
      test_mb00();
      test_mb10();
      test_mb01();
      test_stall();
      test_busy_sat();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
